ripple_carry_adder: RTL and testbench

Parameterised ripple-carry adder, default 4 bits, with a single registered output stage. It adds two unsigned operands and a carry-in, producing a WIDTH-bit sum, carry-out and signed-overflow flag one clock after the operands are sampled. It is a basic arithmetic leaf block for datapaths that need a small, predictable, area-minimal adder.

---
 rtl/ripple_carry_adder_pkg.sv | 13 +
 rtl/ripple_carry_adder_full_adder.sv | 15 +
 rtl/ripple_carry_adder.sv | 59 +++++
 tb/tb_ripple_carry_adder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ripple_carry_adder_pkg.sv
// Shared bit-level helpers for the ripple-carry adder and its full-adder cell.
package ripple_carry_adder_pkg;

  // Carry out of a full-adder cell: two-of-three majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    fa_sum = a ^ b ^ c;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full-adder cell, purely combinational; chained by the top into a ripple adder.
module full_adder
  import ripple_carry_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = fa_sum(a, b, cin);
  assign cout = maj3(a, b, cin);

endmodule

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder with one registered output stage (sum, carry-out, overflow).
// Timing: x[0]/y[0]/c ripple through WIDTH carry cells into the C/V registers; constrain as O(WIDTH).
module ripple_carry_adder
  import ripple_carry_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   w_k;
  logic [WIDTH-1:0] w_s;
  logic             w_v;

  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             r_v;

  assign w_k[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a    (x[i]),
      .b    (y[i]),
      .cin  (w_k[i]),
      .sum  (w_s[i]),
      .cout (w_k[i+1])
    );
  end

  // Signed overflow: carry into the MSB differs from carry out of it (for WIDTH=1 that is c vs k[1]).
  assign w_v = w_k[WIDTH] ^ w_k[MSB];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= '0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else begin
      r_s <= w_s;
      r_c <= w_k[WIDTH];
      r_v <= w_v;
    end
  end

  assign S = r_s;
  assign C = r_c;
  assign V = r_v;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench: WIDTH=4, 1 and 32 adders driven in lockstep, results checked via a 1-cycle scoreboard.
module tb_ripple_carry_adder;

  typedef struct packed {
    logic        rst;
    logic [3:0]  x4;
    logic [3:0]  y4;
    logic        c4;
    logic        x1;
    logic        y1;
    logic        c1;
    logic [31:0] x32;
    logic [31:0] y32;
    logic        c32;
  } in_t;

  typedef struct packed {
    logic [3:0]  s4;
    logic        c4;
    logic        v4;
    logic        s1;
    logic        c1;
    logic        v1;
    logic [31:0] s32;
    logic        c32;
    logic        v32;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  x4, y4, S4;
  logic        c4, C4, V4;
  logic        x1, y1, S1;
  logic        c1, C1, V1;
  logic [31:0] x32, y32, S32;
  logic        c32, C32, V32;

  int errors = 0;
  int checks = 0;
  int step_no = 0;
  out_t sb_q[$];
  vec_t tbl[0:7];

  ripple_carry_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .x(x4), .y(y4), .c(c4), .S(S4), .C(C4), .V(V4)
  );
  ripple_carry_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .c(c1), .S(S1), .C(C1), .V(V1)
  );
  ripple_carry_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .x(x32), .y(y32), .c(c32), .S(S32), .C(C32), .V(V32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact wide addition; overflow from operand/result sign bits.
  function automatic out_t model(input in_t i);
    out_t        o;
    logic [4:0]  t4;
    logic [1:0]  t1;
    logic [32:0] t32;
    o = '0;
    if (!i.rst) begin
      t4  = {1'b0, i.x4} + {1'b0, i.y4} + {4'b0, i.c4};
      t1  = {1'b0, i.x1} + {1'b0, i.y1} + {1'b0, i.c1};
      t32 = {1'b0, i.x32} + {1'b0, i.y32} + {32'b0, i.c32};
      o.s4  = t4[3:0];
      o.c4  = t4[4];
      o.v4  = (i.x4[3] == i.y4[3]) && (t4[3] != i.x4[3]);
      o.s1  = t1[0];
      o.c1  = t1[1];
      o.v1  = (i.x1 == i.y1) && (t1[0] != i.x1);
      o.s32 = t32[31:0];
      o.c32 = t32[32];
      o.v32 = (i.x32[31] == i.y32[31]) && (t32[31] != i.x32[31]);
    end
    return o;
  endfunction

  function automatic in_t rand_in(input logic r);
    in_t i;
    i.rst = r;
    i.x4  = 4'($urandom_range(0, 15));
    i.y4  = 4'($urandom_range(0, 15));
    i.c4  = 1'($urandom_range(0, 1));
    i.x1  = 1'($urandom_range(0, 1));
    i.y1  = 1'($urandom_range(0, 1));
    i.c1  = 1'($urandom_range(0, 1));
    i.x32 = $urandom;
    i.y32 = $urandom;
    i.c32 = 1'($urandom_range(0, 1));
    return i;
  endfunction

  // Drive one vector just after a rising edge; at the following falling edge the
  // outputs must hold the result of the vector driven one step earlier.
  task automatic step(input in_t i, input out_t e);
    out_t exp_o;
    @(posedge clk);
    #1;
    rst = i.rst;
    x4 = i.x4;   y4 = i.y4;   c4 = i.c4;
    x1 = i.x1;   y1 = i.y1;   c1 = i.c1;
    x32 = i.x32; y32 = i.y32; c32 = i.c32;
    sb_q.push_back(e);
    @(negedge clk);
    step_no++;
    if (sb_q.size() > 1) begin
      exp_o = sb_q.pop_front();
      checks++;
      if ({S4, C4, V4} !== {exp_o.s4, exp_o.c4, exp_o.v4}) begin
        errors++;
        $display("FAIL w4 step=%0d got S=%h C=%b V=%b expected S=%h C=%b V=%b",
                 step_no, S4, C4, V4, exp_o.s4, exp_o.c4, exp_o.v4);
      end
      checks++;
      if ({S1, C1, V1} !== {exp_o.s1, exp_o.c1, exp_o.v1}) begin
        errors++;
        $display("FAIL w1 step=%0d got S=%b C=%b V=%b expected S=%b C=%b V=%b",
                 step_no, S1, C1, V1, exp_o.s1, exp_o.c1, exp_o.v1);
      end
      checks++;
      if ({S32, C32, V32} !== {exp_o.s32, exp_o.c32, exp_o.v32}) begin
        errors++;
        $display("FAIL w32 step=%0d got S=%h C=%b V=%b expected S=%h C=%b V=%b",
                 step_no, S32, C32, V32, exp_o.s32, exp_o.c32, exp_o.v32);
      end
    end
  endtask

  initial begin
    in_t  iv;
    rst = 1'b1;
    x4 = '0; y4 = '0; c4 = 1'b0;
    x1 = 1'b0; y1 = 1'b0; c1 = 1'b0;
    x32 = '0; y32 = '0; c32 = 1'b0;

    // Directed vectors: {rst, x4,y4,c4, x1,y1,c1, x32,y32,c32} -> {s4,c4,v4, s1,c1,v1, s32,c32,v32}
    tbl[0].i = '{1'b1, 4'd15, 4'd15, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0};
    tbl[0].e = '{4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
    tbl[1].i = tbl[0].i;
    tbl[1].e = tbl[0].e;
    tbl[2].i = '{1'b0, 4'd15, 4'd15, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0};
    tbl[2].e = '{4'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0};
    tbl[3].i = '{1'b0, 4'd9, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0};
    tbl[3].e = '{4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[4].i = '{1'b0, 4'd15, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0};
    tbl[4].e = '{4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};
    tbl[5].i = '{1'b0, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0};
    tbl[5].e = '{4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 1'b1, 1'b1};
    tbl[6].i = '{1'b0, 4'd3, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'd1, 1'b1};
    tbl[6].e = '{4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_567A, 1'b0, 1'b0};
    tbl[7].i = '{1'b0, 4'd10, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0};
    tbl[7].e = '{4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0};

    for (int n = 0; n < 8; n++) begin
      step(tbl[n].i, tbl[n].e);
    end

    // Exhaustive 4-bit sweep with random 1- and 32-bit traffic alongside.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          iv = rand_in(1'b0);
          iv.x4 = 4'(a);
          iv.y4 = 4'(b);
          iv.c4 = 1'(ci);
          step(iv, model(iv));
        end
      end
    end

    // Random stream with single-cycle reset pulse, then a three-cycle held reset.
    for (int n = 0; n < 30; n++) begin
      iv = rand_in((n == 12) || (n >= 20 && n < 23));
      step(iv, model(iv));
    end

    // Flush: lets the final queued result be compared.
    iv = rand_in(1'b0);
    step(iv, model(iv));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
